// File: rtl/led_counter_pkg.sv
// -----------------------------------------------------------------------------
// led_counter_pkg
//   Shared board-level constants for the LED heartbeat timer, plus a small
//   helper that checks a terminal count against the counter width.
//   CLK_FREQ_HZ    : board system clock frequency.
//   HALF_SEC_CNT   : terminal count for a 0.5 s half-period at CLK_FREQ_HZ.
//   HALF_SEC_CNT_W : counter width that holds HALF_SEC_CNT.
// -----------------------------------------------------------------------------
package led_counter_pkg;

  localparam int unsigned CLK_FREQ_HZ    = 50_000_000;
  localparam int unsigned HALF_SEC_CNT   = (CLK_FREQ_HZ / 2) - 1;  // 24_999_999
  localparam int unsigned HALF_SEC_CNT_W = 25;

  // True when cnt_max is representable in a cnt_w-bit counter.
  function automatic bit cnt_fits(input longint unsigned cnt_max,
                                  input int unsigned     cnt_w);
    return cnt_max < (64'd1 << cnt_w);
  endfunction

endpackage

// File: rtl/led_counter_if.sv
// -----------------------------------------------------------------------------
// led_counter_if
//   Tick bundle between the cycle counter (tick_gen) and the LED toggle flop.
//   cnt      : current cycle count, 0..CNT_MAX.
//   cnt_flag : high exactly during the cycle in which cnt == CNT_MAX.
//   master   : driven by tick_gen.
//   slave    : consumed by the LED toggle stage.
//   monitor  : read-only view of the whole bundle.
// -----------------------------------------------------------------------------
interface led_counter_if #(
  parameter int unsigned CNT_W = 25
);

  logic [CNT_W-1:0] cnt;
  logic             cnt_flag;

  modport master  (output cnt, output cnt_flag);
  modport slave   (input  cnt_flag);
  modport monitor (input  cnt, input cnt_flag);

endinterface

// File: rtl/led_counter_tick_gen.sv
// -----------------------------------------------------------------------------
// led_counter_tick_gen
//   Free-running counter 0..CNT_MAX with a registered wrap flag.
//   sys_clk   : system clock, rising edge.
//   sys_rst_n : synchronous reset, active HIGH despite the suffix.
//   tick      : master side of the tick bundle (cnt, cnt_flag).
// -----------------------------------------------------------------------------
module led_counter_tick_gen
  import led_counter_pkg::*;
#(
  parameter int unsigned CNT_MAX = HALF_SEC_CNT,
  parameter int unsigned CNT_W   = HALF_SEC_CNT_W
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  led_counter_if.master tick
);

  if (!cnt_fits(longint'(CNT_MAX), CNT_W)) begin : g_bad_width
    $fatal(1, "led_counter_tick_gen: CNT_MAX does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_flag;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the reset branch is inside the clocked block, making
  // it synchronous.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX_V) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  if (CNT_MAX == 0) begin : g_flag_const
    // Every cycle is a wrap cycle, so the flag never drops.
    assign cnt_flag = 1'b1;
  end else begin : g_flag_reg
    // Decode one count early so the registered flag lines up with cnt == CNT_MAX.
    localparam logic [CNT_W-1:0] PRE_MAX_V = CNT_W'(CNT_MAX - 1);
    logic flag_q;

    always_ff @(posedge sys_clk) begin
      if (sys_rst_n) begin
        flag_q <= 1'b0;
      end else begin
        flag_q <= (cnt_q == PRE_MAX_V);
      end
    end

    assign cnt_flag = flag_q;
  end

  assign tick.cnt      = cnt_q;
  assign tick.cnt_flag = cnt_flag;

endmodule

// File: rtl/led_counter.sv
// -----------------------------------------------------------------------------
// led_counter
//   LED heartbeat: led_out toggles once every CNT_MAX+1 cycles (50 % duty).
//   sys_clk   : system clock, rising edge.
//   sys_rst_n : synchronous reset, active HIGH despite the suffix.
//   led_out   : registered LED drive, LED_INIT while in reset.
// -----------------------------------------------------------------------------
module led_counter
  import led_counter_pkg::*;
#(
  parameter int unsigned CNT_MAX  = HALF_SEC_CNT,
  parameter int unsigned CNT_W    = HALF_SEC_CNT_W,
  parameter logic        LED_INIT = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic led_out
);

  led_counter_if #(.CNT_W(CNT_W)) tick_bus ();

  led_counter_tick_gen #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick_bus.master)
  );

  // Reset has priority, so a wrap coinciding with reset produces no toggle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      led_out <= LED_INIT;
    end else if (tick_bus.cnt_flag) begin
      led_out <= ~led_out;
    end
  end

endmodule

// File: tb/tb_led_counter.sv
// -----------------------------------------------------------------------------
// tb_led_counter
//   Directed bench for led_counter with CNT_MAX = 24 (main instance) plus
//   CNT_MAX = 0 and CNT_MAX = 1 instances sharing clock and reset.
//   Expected values are written as functions of the edge number n counted
//   from the first edge with reset deasserted.
// -----------------------------------------------------------------------------
module tb_led_counter;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic led24;
  logic led0;
  logic led1;

  int tests = 0;
  int fails = 0;

  always #10 sys_clk = ~sys_clk;

  led_counter #(.CNT_MAX(24), .CNT_W(5), .LED_INIT(1'b0)) dut24 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led_out   (led24)
  );

  led_counter #(.CNT_MAX(0), .CNT_W(1), .LED_INIT(1'b0)) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led_out   (led0)
  );

  led_counter #(.CNT_MAX(1), .CNT_W(2), .LED_INIT(1'b0)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led_out   (led1)
  );

  // Observation bundle for the main instance's internal tick signals.
  led_counter_if #(.CNT_W(5)) probe ();
  assign probe.cnt      = dut24.tick_bus.cnt;
  assign probe.cnt_flag = dut24.tick_bus.cnt_flag;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset(input string phase);
    check({phase, " cnt24"},  32'(probe.cnt), 0);
    check({phase, " flag24"}, 32'(probe.cnt_flag), 0);
    check({phase, " led24"},  32'(led24), 0);
    check({phase, " cnt0"},   32'(dut0.tick_bus.cnt), 0);
    check({phase, " led0"},   32'(led0), 0);
    check({phase, " cnt1"},   32'(dut1.tick_bus.cnt), 0);
    check({phase, " led1"},   32'(led1), 0);
  endtask

  // Edges first..last after release; n is the edge index since release.
  task automatic check_window(input string phase, input int first, input int last);
    for (int n = first; n <= last; n++) begin
      step();
      check($sformatf("%s cnt24@%0d", phase, n),  32'(probe.cnt), n % 25);
      check($sformatf("%s flag24@%0d", phase, n), 32'(probe.cnt_flag), (n % 25 == 24) ? 1 : 0);
      check($sformatf("%s led24@%0d", phase, n),  32'(led24), (n / 25) % 2);
      check($sformatf("%s cnt0@%0d", phase, n),   32'(dut0.tick_bus.cnt), 0);
      check($sformatf("%s led0@%0d", phase, n),   32'(led0), n % 2);
      check($sformatf("%s cnt1@%0d", phase, n),   32'(dut1.tick_bus.cnt), n % 2);
      check($sformatf("%s led1@%0d", phase, n),   32'(led1), (n / 2) % 2);
    end
  endtask

  initial begin
    // Power-on reset held over two edges.
    sys_rst_n = 1'b1;
    step();
    step();
    check_reset("por");

    // Free run: led24 rises at 25, falls at 50, rises at 75; stop at cnt == 12.
    sys_rst_n = 1'b0;
    check_window("run", 1, 87);

    // One-cycle reset at cnt == 12 while led24 is high.
    sys_rst_n = 1'b1;
    step();
    check_reset("mid");

    // Restart from 0; run up to the cnt == 24 cycle with led24 low.
    sys_rst_n = 1'b0;
    check_window("restart", 1, 74);

    // Reset in the wrap cycle: a toggle would drive led24 high, reset keeps it low.
    sys_rst_n = 1'b1;
    step();
    check_reset("wrap");

    sys_rst_n = 1'b0;
    check_window("after_wrap", 1, 26);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
